// File: rtl/display_source_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display among four 32-bit sources,
// with a minimum dwell time per owner so each value stays readable before switching.
module display_source_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned HOLD  = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] src_data,
    input  logic         lock,
    output logic [31:0]  Leddata,
    output logic [3:0]   grant,
    output logic [1:0]   owner,
    output logic         valid,
    output logic         switch_pulse
);

    localparam int unsigned DW = $clog2(HOLD);
    localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [31:0]   led_q, led_d;
    logic [3:0]    grant_q, grant_d;
    logic          pulse_q, pulse_d;

    logic          other_found;
    logic [1:0]    other_idx;
    logic [1:0]    pick_idx;
    logic [31:0]   owner_word;
    logic [31:0]   other_word;
    logic [31:0]   pick_word;
    logic          expired;

    // Search starts just after the current owner, so the owner itself ranks last.
    always_comb begin
        other_found = 1'b0;
        other_idx   = owner_q;
        for (int unsigned i = 1; i < N_SRC; i++) begin
            if (!other_found && req[owner_q + 2'(i)]) begin
                other_found = 1'b1;
                other_idx   = owner_q + 2'(i);
            end
        end
    end

    assign pick_idx   = other_found ? other_idx : owner_q;
    assign owner_word = src_data[{owner_q, 5'd0} +: 32];
    assign other_word = src_data[{other_idx, 5'd0} +: 32];
    assign pick_word  = other_found ? other_word : owner_word;
    assign expired    = (dwell_q == DWELL_MAX);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dwell_d = dwell_q;
        led_d   = led_q;
        grant_d = grant_q;
        pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if ((|req) && !lock) begin
                    state_d = SHOW;
                    owner_d = pick_idx;
                    dwell_d = '0;
                    led_d   = pick_word;
                    grant_d = 4'(4'b0001 << pick_idx);
                    pulse_d = 1'b1;
                end
            end

            SHOW: begin
                if (!expired) begin
                    dwell_d = dwell_q + 1'b1;
                end
                if (req[owner_q]) begin
                    led_d = owner_word;
                end
                // A switch overrides the owner's own data update on the same edge.
                if (!lock && expired) begin
                    if (other_found) begin
                        owner_d = other_idx;
                        dwell_d = '0;
                        led_d   = other_word;
                        grant_d = 4'(4'b0001 << other_idx);
                        pulse_d = 1'b1;
                    end else if (!req[owner_q]) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            dwell_q <= '0;
            led_q   <= '0;
            grant_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dwell_q <= dwell_d;
            led_q   <= led_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
        end
    end

    assign Leddata      = led_q;
    assign grant        = grant_q;
    assign owner        = owner_q;
    assign valid        = (state_q == SHOW);
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with HOLD=4: a vector table for the
// reset, rotation and dwell/freeze cases, plus hand sequences for lock, reset and sole owner.
module tb_display_source_arbiter;

    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         lock;
    logic [3:0]   req;
    logic [127:0] src_data;
    logic [31:0]  Leddata;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         valid;
    logic         switch_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_source_arbiter #(
        .N_SRC(4),
        .HOLD (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .src_data    (src_data),
        .lock        (lock),
        .Leddata     (Leddata),
        .grant       (grant),
        .owner       (owner),
        .valid       (valid),
        .switch_pulse(switch_pulse)
    );

    typedef struct {
        logic         rst;
        logic         lock;
        logic [3:0]   req;
        logic [127:0] data;
        logic [3:0]   g;
        logic [1:0]   o;
        logic         v;
        logic         p;
        logic [31:0]  led;
    } vec_t;

    vec_t tbl[$];

    localparam logic [127:0] D_ROT = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001, 32'h0ABC_0000};

    function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
        return d[32*i +: 32];
    endfunction

    task automatic add(input logic r, input logic l, input logic [3:0] rq, input logic [127:0] d,
                       input logic [3:0] g, input logic [1:0] o, input logic v, input logic p,
                       input logic [31:0] led);
        vec_t e;
        e.rst = r; e.lock = l; e.req = rq; e.data = d;
        e.g = g; e.o = o; e.v = v; e.p = p; e.led = led;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic v, input logic p, input logic [31:0] led);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".owner"}, 32'(owner), 32'(o));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".pulse"}, 32'(switch_pulse), 32'(p));
        chk({tag, ".led"}, Leddata, led);
    endtask

    task automatic drive(input logic r, input logic l, input logic [3:0] rq, input logic [127:0] d);
        rst = r; lock = l; req = rq; src_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[6];
        int pulses;
        logic [127:0] d;

        rst = 1'b1; lock = 1'b0; req = '0; src_data = '0;

        // Reset and first grant
        add(1, 0, 4'b0000, '0, 4'b0000, 2'd3, 0, 0, 32'h0);
        add(1, 0, 4'b0000, '0, 4'b0000, 2'd3, 0, 0, 32'h0);
        add(0, 0, 4'b0100, {32'h0, 32'h1234_5678, 64'h0}, 4'b0100, 2'd2, 1, 1, 32'h1234_5678);

        // Rotation with all four requesting: 2 (continued), 3, 0, 1, 2, 3, 0
        for (int k = 0; k < 3; k++) add(0, 0, 4'b1111, D_ROT, 4'b0100, 2'd2, 1, 0, 32'h2000_0002);
        seq = '{3, 0, 1, 2, 3, 0};
        for (int s = 0; s < 6; s++) begin
            add(0, 0, 4'b1111, D_ROT, 4'(4'b0001 << seq[s]), 2'(seq[s]), 1, 1, word_of(D_ROT, seq[s]));
            for (int k = 0; k < 3; k++)
                add(0, 0, 4'b1111, D_ROT, 4'(4'b0001 << seq[s]), 2'(seq[s]), 1, 0, word_of(D_ROT, seq[s]));
        end

        // Owner 1 drops req at dwell=1, freeze, then IDLE at expiry
        add(1, 0, 4'b0000, '0, 4'b0000, 2'd3, 0, 0, 32'h0);
        add(0, 0, 4'b0010, {64'h0, 32'hA1A1_0001, 32'h0}, 4'b0010, 2'd1, 1, 1, 32'hA1A1_0001);
        add(0, 0, 4'b0010, {64'h0, 32'hA1A1_0002, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0003, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0004, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0005, 32'h0}, 4'b0000, 2'd1, 0, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0006, 32'h0}, 4'b0000, 2'd1, 0, 0, 32'hA1A1_0002);
        // From IDLE with owner 1 retained, search starts at 2 and wraps to 0
        add(0, 0, 4'b0011, {64'h0, 32'hA1A1_0007, 32'hC0C0_0000}, 4'b0001, 2'd0, 1, 1, 32'hC0C0_0000);

        // Same freeze, but source 3 requests at expiry
        add(1, 0, 4'b0000, '0, 4'b0000, 2'd3, 0, 0, 32'h0);
        add(0, 0, 4'b0010, {64'h0, 32'hA1A1_0001, 32'h0}, 4'b0010, 2'd1, 1, 1, 32'hA1A1_0001);
        add(0, 0, 4'b0010, {64'h0, 32'hA1A1_0002, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0003, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b0000, {64'h0, 32'hA1A1_0004, 32'h0}, 4'b0010, 2'd1, 1, 0, 32'hA1A1_0002);
        add(0, 0, 4'b1000, {32'hB3B3_0003, 96'h0}, 4'b1000, 2'd3, 1, 1, 32'hB3B3_0003);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].lock, tbl[i].req, tbl[i].data);
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].o, tbl[i].v, tbl[i].p, tbl[i].led);
        end

        // Lock blocks the grant out of IDLE, then holds owner 0 against source 1
        drive(1, 0, 4'b0000, '0);
        chk_out("lk_rst", 4'b0000, 2'd3, 0, 0, 32'h0);
        drive(0, 1, 4'b0001, {96'h0, 32'h0D00_0000});
        chk_out("lk_idle", 4'b0000, 2'd3, 0, 0, 32'h0);
        drive(0, 0, 4'b0001, {96'h0, 32'h0D00_0001});
        chk_out("lk_grant", 4'b0001, 2'd0, 1, 1, 32'h0D00_0001);
        for (int c = 0; c < 10; c++) begin
            d = {64'h0, 32'h1D00_0000, 32'h0D00_0100 + 32'(c)};
            drive(0, 1, 4'b0011, d);
            chk_out($sformatf("lk_hold%0d", c), 4'b0001, 2'd0, 1, 0, 32'h0D00_0100 + 32'(c));
        end
        drive(0, 0, 4'b0011, {64'h0, 32'h1D00_0000, 32'h0D00_0200});
        chk_out("lk_release", 4'b0010, 2'd1, 1, 1, 32'h1D00_0000);

        // Reset pulse with owner 2 at dwell=2
        drive(1, 0, 4'b0000, '0);
        drive(0, 0, 4'b0100, {32'h0, 32'h2E00_0000, 64'h0});
        chk_out("mr_grant", 4'b0100, 2'd2, 1, 1, 32'h2E00_0000);
        drive(0, 0, 4'b0100, {32'h0, 32'h2E00_0001, 64'h0});
        drive(0, 0, 4'b0100, {32'h0, 32'h2E00_0002, 64'h0});
        chk_out("mr_dwell2", 4'b0100, 2'd2, 1, 0, 32'h2E00_0002);
        drive(1, 0, 4'b0110, {32'h0, 32'h2E00_0003, 32'h1E00_0000, 32'h0});
        chk_out("mr_reset", 4'b0000, 2'd3, 0, 0, 32'h0);
        drive(0, 0, 4'b0110, {32'h0, 32'h2E00_0004, 32'h1E00_0001, 32'h0});
        chk_out("mr_regrant", 4'b0010, 2'd1, 1, 1, 32'h1E00_0001);

        // Sole owner keeps the display with live data
        drive(1, 0, 4'b0000, '0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 4'b0001, {96'h0, 32'h5000_0000 + 32'(c)});
            if (switch_pulse) pulses++;
            chk_out($sformatf("so%0d", c), 4'b0001, 2'd0, 1, (c == 0), 32'h5000_0000 + 32'(c));
        end
        chk("so_pulses", 32'(pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
# display_source_arbiter

Time-shares the 8-digit seven-segment display between up to four 32-bit requesters (e.g. PC, register probe, memory probe, syscall output) and drives the single `Leddata` word consumed by the display driver. Round-robin grant with a minimum dwell time per owner, so every value stays readable before the display switches. Sits between the CPU debug taps and the `show` display block. It is clocked by the same system clock.

## Interface
- `N_SRC`, default 4: number of requesters; fixed at 4 in this revision.
- `HOLD`, default 50_000_000: minimum dwell in clk cycles; must be ≥ 2. Benches use 4.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  per-source display request; level-sensitive.
- `src_data`  input  128  source i word at bits [32i+31:32i].
- `lock`  input  1  when high, owner may not change; dwell counter keeps running, saturating.
- `Leddata`  output  32  registered word for the display driver.
- `grant`  output  4  registered one-hot owner; all-zero when idle.
- `owner`  output  2  registered index of current or last owner.
- `valid`  output  1  high while a source owns the display.
- `switch_pulse`  output  1  one-cycle pulse on every owner change, including the first grant from IDLE.

## Operation
- Two states: IDLE (no owner) and SHOW (owner granted).
- Round-robin search order starts at `owner`+1 mod 4 and wraps. It ends at `owner`, so the current owner has the lowest priority.
- IDLE:
  - Outputs: `valid`=0, `grant`=0.
  - `Leddata` holds the last shown value, or 0 after reset.
  - If any `req` bit is set and `lock`=0: take the first requester in search order, enter SHOW, clear the dwell counter, and set `switch_pulse`.
  - `lock` blocks the grant out of IDLE.
- SHOW, dwell counter `dwell`:
  - `dwell` increments each cycle and saturates at HOLD-1.
  - "Expired" means `dwell`==HOLD-1.
  - While `req[owner]`=1, `Leddata` follows `src_data[owner]` every cycle.
  - While `req[owner]`=0, `Leddata` freezes at its last value.
- Switch decision on each cycle in SHOW with `lock`=0 and `dwell` expired:
  - If another source requests, grant the first such source in search order. Load `Leddata` from that source's data and reset `dwell` to 0, on the same edge. `switch_pulse`=1.
  - If no other source requests and `req[owner]`=1, keep the owner. `dwell` stays saturated and there is no pulse.
  - If no source requests at all, go to IDLE.
  - `owner` keeps the old index in IDLE so round-robin fairness carries over.
- Before expiry, nothing changes ownership. This holds even if the owner drops `req`; the frozen value keeps showing.
- `lock`=1 in SHOW suppresses every ownership change and the IDLE transition. On the first unlocked cycle with `dwell` expired, the switch rule above applies immediately.
- `switch_pulse` is 0 in every cycle without an ownership change.

## Timing
- Reset (`rst` high at a rising edge) sets:
  - state IDLE, `dwell`=0
  - `Leddata`=0, `grant`=0, `valid`=0, `switch_pulse`=0
  - `owner`=3, so the first search starts at source 0.
- Reset mid-SHOW aborts ownership on that edge. Requests seen in the same cycle are ignored until the cycle after `rst` falls.
- Grant latency: a `req` sampled high at edge k in IDLE gives the following, all registered at edge k:
  - `grant`, `owner`, `valid`=1 and `switch_pulse`=1
  - `Leddata`=`src_data` of that source sampled at edge k
- Data latency: `Leddata` lags `src_data[owner]` by one cycle.
- Dwell: after a grant at edge k, the earliest next owner change is at edge k+HOLD. A switch happens at edge k+HOLD if a competing request is sampled there.
- Simultaneous requests are resolved purely by search order; there is no fixed priority.
- `req` changes are not registered; the values sampled at the decision edge apply.

## Test plan
- Reset/first grant, HOLD=4:
  - Stimulus: `rst` high for 2 cycles, then `req`=0100 with src2=0x1234_5678.
  - Response: all outputs 0 and `owner`=3 during reset. One cycle after `req`: `grant`=0100, `owner`=2, `valid`=1, one `switch_pulse`, `Leddata`=0x1234_5678.
- Round-robin rotation:
  - Stimulus: `req`=1111 held, sources return 0x0..., 0x1..., 0x2..., 0x3....
  - Response: owner sequence 0,1,2,3,0. Each owner is held exactly 4 cycles, with exactly one `switch_pulse` per change.
- Dwell protection and freeze:
  - Stimulus: owner 1 drops `req` at dwell=1 while src1 keeps changing.
  - Response: `Leddata` frozen at the last src1 value. At expiry, go to IDLE with `valid`=0, `grant`=0 and `Leddata` unchanged. With `req`=1000 at expiry instead, grant source 3.
- Lock:
  - Stimulus: `lock`=1 while owner 0 is shown, `req`=0011, for 10 cycles.
  - Response: no switch and no pulse during lock. On the first cycle after `lock` falls, switch to source 1.
- Reset mid-operation:
  - Stimulus: `rst` pulsed one cycle during SHOW with owner 2 and dwell=2.
  - Response: all outputs return to reset values, `owner`=3. The next grant goes to the lowest-index requester.
- Sole owner persistence:
  - Stimulus: `req`=0001 held 20 cycles with live data.
  - Response: owner stays 0, single `switch_pulse` at the start, `Leddata` tracks src0 with one-cycle lag.
